// File: rtl/uart_receive_controller_pkg.sv
// Shared UART controller state types and helpers for the TX/RX halves.
// Optional macro UART_RX_MAJORITY_VOTE_EN is consumed by the RX bit sampler.
package uart_receive_controller_pkg;

  typedef enum logic [1:0] {
    S_TXC_IDLE,
    S_TXC_START_BIT,
    S_TXC_DATA,
    S_TXC_STOP_BIT
  } TX_Controller_state_type;

  typedef enum logic [1:0] {
    S_RXC_IDLE,
    S_RXC_START_BIT,
    S_RXC_DATA,
    S_RXC_STOP_BIT
  } RX_Controller_state_type;

  localparam int RX_DATA_W = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receive_controller_bit_sampler.sv
// RX pin synchronizer plus per-enable sample value; with UART_RX_MAJORITY_VOTE_EN
// defined the sample is a 2-of-3 vote over the last three enabled ticks.
module uart_rx_bit_sampler
  import uart_receive_controller_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_sample
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_rx};
  end

  assign o_rx_s = r_sync[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two previous enabled-tick samples; combined with the current rx_s the
  // vote spans ticks T-2..T when the controller decides at tick T.
  logic [1:0] r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_hist <= 2'b11;
    else if (i_en) r_hist <= {r_hist[0], r_sync[1]};
  end

  assign o_sample = maj3(r_hist[1], r_hist[0], r_sync[1]);
`else
  assign o_sample = r_sync[1];
`endif

endmodule

// File: rtl/uart_receive_controller.sv
// UART 8N1 receiver: oversampled deserializer, one-entry buffer, framing/overrun flags.
// Optional macro UART_RX_MAJORITY_VOTE_EN selects 3-sample majority bit decisions.
module uart_receive_controller
  import uart_receive_controller_pkg::*;
#(
  parameter int OVERSAMPLE_RATE = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 RX_clock_enable,
  input  logic                 Unload_data,
  input  logic                 UART_RX_I,
  output logic [RX_DATA_W-1:0] RX_data,
  output logic                 Empty,
  output logic                 Frame_error,
  output logic                 Overrun_error
);

  localparam int TW = $clog2(OVERSAMPLE_RATE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE_RATE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote window MID-1..MID+1 completes one tick later; later bits inherit the shift.
  localparam logic [TW-1:0] START_PT = MID + 1'b1;
`else
  localparam logic [TW-1:0] START_PT = MID;
`endif

  RX_Controller_state_type r_state, w_next;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [2:0]           r_bit, w_bit_nxt;
  logic [RX_DATA_W-1:0] r_shift, w_shift_nxt;
  logic [RX_DATA_W-1:0] r_data;
  logic                 r_empty, r_ferr, r_oerr;
  logic                 w_rx_s, w_sample, w_load, w_ferr;

  uart_rx_bit_sampler u_sampler (
    .i_clk    (Clock),
    .i_rst_n  (Resetn),
    .i_en     (RX_clock_enable),
    .i_rx     (UART_RX_I),
    .o_rx_s   (w_rx_s),
    .o_sample (w_sample)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_RXC_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    if (RX_clock_enable) begin
      case (r_state)
        S_RXC_IDLE: begin
          w_tick_nxt = '0;
          if (!w_rx_s) w_next = S_RXC_START_BIT;
        end
        S_RXC_START_BIT: begin
          if (r_tick == START_PT) begin
            // Restarting the tick count here centres later samples mid-bit.
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            w_next     = w_sample ? S_RXC_IDLE : S_RXC_DATA;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_RXC_DATA: begin
          w_tick_nxt = r_tick + 1'b1;
          if (r_tick == LAST) begin
            w_shift_nxt = {w_sample, r_shift[RX_DATA_W-1:1]};
            if (r_bit == 3'd7) w_next = S_RXC_STOP_BIT;
            else               w_bit_nxt = r_bit + 3'd1;
          end
        end
        S_RXC_STOP_BIT: begin
          w_tick_nxt = r_tick + 1'b1;
          if (r_tick == LAST) begin
            w_load = w_sample;
            w_ferr = ~w_sample;
            w_next = S_RXC_IDLE;
          end
        end
        default: begin
          w_next     = S_RXC_IDLE;
          w_tick_nxt = '0;
        end
      endcase
    end
  end

  // Consumer side: a completing byte beats a same-cycle unload, and a
  // same-cycle unload suppresses the overrun it would otherwise cause.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_data  <= '0;
      r_empty <= 1'b1;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_empty <= 1'b0;
      end else if (Unload_data) begin
        r_empty <= 1'b1;
      end
      if (Unload_data) begin
        r_ferr <= 1'b0;
        r_oerr <= 1'b0;
      end
      if (w_ferr) r_ferr <= 1'b1;
      if (w_load && !r_empty && !Unload_data) r_oerr <= 1'b1;
    end
  end

  assign RX_data       = r_data;
  assign Empty         = r_empty;
  assign Frame_error   = r_ferr;
  assign Overrun_error = r_oerr;

endmodule

// File: tb/tb_uart_receive_controller.sv
// Directed bench for uart_receive_controller: frame-level reference model plus
// hand-computed expectations; one enable every 4 clocks, 16 enables per bit.
module tb_uart_receive_controller;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       RX_clock_enable = 1'b0;
  logic       Unload_data = 1'b0;
  logic       UART_RX_I = 1'b1;
  logic [7:0] RX_data;
  logic       Empty, Frame_error, Overrun_error;

  uart_receive_controller #(.OVERSAMPLE_RATE(16)) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .RX_clock_enable (RX_clock_enable),
    .Unload_data     (Unload_data),
    .UART_RX_I       (UART_RX_I),
    .RX_data         (RX_data),
    .Empty           (Empty),
    .Frame_error     (Frame_error),
    .Overrun_error   (Overrun_error)
  );

  always #5 Clock = ~Clock;

  // Enable index within a frame (start edge driven before enable 0) at which
  // the stop bit is decided: 2-flop sync + start detect + 9.5 bit periods.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int SAMPLE_IDX = 154;
`else
  localparam int SAMPLE_IDX = 153;
`endif

  int   n_chk = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_empty = 1'b1, m_fe = 1'b0, m_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge Clock) begin
    #1;
    if (chk_en) begin
      check("cyc_RX_data", {24'd0, RX_data}, {24'd0, m_data});
      check("cyc_Empty", {31'd0, Empty}, {31'd0, m_empty});
      check("cyc_Frame_error", {31'd0, Frame_error}, {31'd0, m_fe});
      check("cyc_Overrun_error", {31'd0, Overrun_error}, {31'd0, m_ov});
    end
  end

  task automatic tick_en(input bit unl);
    @(negedge Clock);
    RX_clock_enable = 1'b1;
    Unload_data     = unl;
    @(negedge Clock);
    RX_clock_enable = 1'b0;
    Unload_data     = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic idle(input int n);
    repeat (n) tick_en(1'b0);
  endtask

  task automatic unload();
    chk_en = 1'b0;
    @(negedge Clock);
    Unload_data = 1'b1;
    @(negedge Clock);
    Unload_data = 1'b0;
    m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int unl_idx,
                            input int rst_idx, input bit spike, input bit lat);
    logic [9:0] bits;
    int idx;
    bits = {stop, d, 1'b0};
    idx  = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 16; k++) begin
        UART_RX_I = bits[b];
        if (spike && b >= 1 && b <= 8 && k == 7) UART_RX_I = ~bits[b];
        if (idx == 150) chk_en = 1'b0;
        if (idx == rst_idx) begin
          chk_en = 1'b0;
          Resetn = 1'b0;
          repeat (2) @(negedge Clock);
          check("rst_RX_data", {24'd0, RX_data}, 32'h00);
          check("rst_Empty", {31'd0, Empty}, 32'd1);
          check("rst_Frame_error", {31'd0, Frame_error}, 32'd0);
          check("rst_Overrun_error", {31'd0, Overrun_error}, 32'd0);
          m_data = 8'h00; m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
          UART_RX_I = 1'b1;
          @(negedge Clock);
          Resetn = 1'b1;
          chk_en = 1'b1;
          return;
        end
        if (lat && idx == SAMPLE_IDX) check("lat_Empty_before", {31'd0, Empty}, 32'd1);
        tick_en(idx == unl_idx);
        if (lat && idx == SAMPLE_IDX) check("lat_Empty_after", {31'd0, Empty}, 32'd0);
        idx++;
      end
    end
    // Frame-level outcome from the buffer/flag rules.
    if (unl_idx >= 0) begin
      m_empty = 1'b1; m_fe = 1'b0; m_ov = 1'b0;
    end
    if (stop) begin
      if (!m_empty) m_ov = 1'b1;
      m_data  = d;
      m_empty = 1'b0;
    end else begin
      m_fe = 1'b1;
    end
    UART_RX_I = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("init_RX_data", {24'd0, RX_data}, 32'h00);
    check("init_Empty", {31'd0, Empty}, 32'd1);
    check("init_Frame_error", {31'd0, Frame_error}, 32'd0);
    check("init_Overrun_error", {31'd0, Overrun_error}, 32'd0);
    Resetn = 1'b1;
    idle(4);
    chk_en = 1'b1;

    send_frame(8'hA5, 1'b1, -1, -1, 1'b0, 1'b1);
    idle(8);
    check("a5_RX_data", {24'd0, RX_data}, 32'hA5);
    check("a5_Empty", {31'd0, Empty}, 32'd0);
    check("a5_errors", {30'd0, Frame_error, Overrun_error}, 32'd0);
    unload();
    idle(2);
    check("a5_unload_Empty", {31'd0, Empty}, 32'd1);

    UART_RX_I = 1'b0;
    idle(3);
    UART_RX_I = 1'b1;
    idle(40);
    check("glitch_Empty", {31'd0, Empty}, 32'd1);
    check("glitch_RX_data", {24'd0, RX_data}, 32'hA5);

    send_frame(8'h3C, 1'b0, -1, -1, 1'b0, 1'b0);
    idle(8);
    check("ferr_Frame_error", {31'd0, Frame_error}, 32'd1);
    check("ferr_Empty", {31'd0, Empty}, 32'd1);
    check("ferr_RX_data", {24'd0, RX_data}, 32'hA5);
    unload();
    idle(2);

    send_frame(8'h11, 1'b1, -1, -1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0, 1'b0);
    idle(8);
    check("ovr_RX_data", {24'd0, RX_data}, 32'h22);
    check("ovr_Overrun_error", {31'd0, Overrun_error}, 32'd1);
    unload();
    idle(2);
    check("ovr_unload_Empty", {31'd0, Empty}, 32'd1);
    check("ovr_unload_Overrun", {31'd0, Overrun_error}, 32'd0);

    send_frame(8'h99, 1'b1, -1, -1, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, SAMPLE_IDX, -1, 1'b0, 1'b0);
    idle(8);
    check("same_RX_data", {24'd0, RX_data}, 32'h7E);
    check("same_Empty", {31'd0, Empty}, 32'd0);
    check("same_Overrun", {31'd0, Overrun_error}, 32'd0);

    send_frame(8'hFF, 1'b1, -1, 16 * 5 + 8, 1'b0, 1'b0);
    idle(40);
    send_frame(8'h0F, 1'b1, -1, -1, 1'b0, 1'b0);
    idle(8);
    check("post_rst_RX_data", {24'd0, RX_data}, 32'h0F);
    check("post_rst_Empty", {31'd0, Empty}, 32'd0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    unload();
    idle(2);
    send_frame(8'h55, 1'b1, -1, -1, 1'b1, 1'b0);
    idle(8);
    check("vote_RX_data", {24'd0, RX_data}, 32'h55);
    check("vote_Frame_error", {31'd0, Frame_error}, 32'd0);
`endif

    chk_en = 1'b0;
    @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
